mem_port_arbiter: RTL and testbench

Shares the single external memory port of `riscv_virtual_system` between the core's instruction-fetch and data interfaces. The block sits between the core and `memory_controller`. It arbitrates with data priority and a fetch anti-starvation limit, and keeps one transaction outstanding at a time. It returns responses on the core's native fetch and data handshakes, and an optional watchdog converts a hung access into an error response.

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data, data-first with fetch anti-starvation.
// Optional watchdog abort of hung accesses when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold_i,
    input  logic        i_rd_i,
    input  logic [31:0] i_pc_i,
    output logic        i_accept_o,
    output logic        i_valid_o,
    output logic [31:0] i_inst_o,
    output logic        i_error_o,
    input  logic        d_rd_i,
    input  logic [3:0]  d_wr_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [10:0] d_tag_i,
    output logic        d_accept_o,
    output logic        d_ack_o,
    output logic [31:0] d_rdata_o,
    output logic        d_error_o,
    output logic [10:0] d_resp_tag_o,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        timeout_o
);
    typedef enum logic [1:0] {IDLE, DBUSY, IBUSY} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  starve_cnt;
    logic [10:0] tag_q;
    logic        d_req, d_is_wr, busy;
    logic        grant_d, grant_i;
    logic        done, abort, finish;

    assign d_req   = d_rd_i | (|d_wr_i);
    assign d_is_wr = |d_wr_i;
    assign busy    = (state_q != IDLE);
    assign done    = busy & mem_ready;
    assign finish  = done | abort;

    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state_q == IDLE && !hold_i) begin
            if (d_req && (starve_cnt < LIMIT || !i_rd_i)) grant_d = 1'b1;
            else if (i_rd_i)                               grant_i = 1'b1;
        end
    end

    assign d_accept_o = grant_d;
    assign i_accept_o = grant_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d)      state_d = DBUSY;
                else if (grant_i) state_d = IBUSY;
            end
            DBUSY, IBUSY: if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Any cycle without a pending fetch means nobody is being starved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            starve_cnt <= '0;
        else if (!i_rd_i || grant_i)           starve_cnt <= '0;
        else if (grant_d && starve_cnt < LIMIT) starve_cnt <= starve_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            mem_we       <= 1'b0;
            mem_re       <= 1'b0;
            tag_q        <= '0;
            d_ack_o      <= 1'b0;
            i_valid_o    <= 1'b0;
            d_rdata_o    <= '0;
            i_inst_o     <= '0;
            d_resp_tag_o <= '0;
        end else begin
            d_ack_o   <= 1'b0;
            i_valid_o <= 1'b0;
            if (grant_d) begin
                mem_addr  <= d_addr_i;
                mem_wdata <= d_is_wr ? d_wdata_i : 32'd0;
                mem_wstrb <= d_is_wr ? d_wr_i : 4'd0;
                mem_we    <= d_is_wr;
                mem_re    <= ~d_is_wr;
                tag_q     <= d_tag_i;
            end else if (grant_i) begin
                mem_addr  <= i_pc_i;
                mem_wdata <= '0;
                mem_wstrb <= '0;
                mem_we    <= 1'b0;
                mem_re    <= 1'b1;
            end
            if (finish) begin
                mem_we <= 1'b0;
                mem_re <= 1'b0;
                // Writes and aborted accesses return zero data.
                if (state_q == DBUSY) begin
                    d_ack_o      <= 1'b1;
                    d_rdata_o    <= (done && mem_re) ? mem_rdata : 32'd0;
                    d_resp_tag_o <= tag_q;
                end else begin
                    i_valid_o <= 1'b1;
                    i_inst_o  <= done ? mem_rdata : 32'd0;
                end
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_cnt;
    logic          d_err_q, i_err_q, tmo_q;

    // mem_ready takes precedence over an abort landing in the same cycle.
    assign abort = busy & ~mem_ready & (tmo_cnt == TMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            d_err_q <= 1'b0;
            i_err_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            if (grant_d || grant_i)                       tmo_cnt <= '0;
            else if (busy && !mem_ready && tmo_cnt != TMAX) tmo_cnt <= tmo_cnt + 1'b1;
            if (finish && state_q == DBUSY) d_err_q <= abort;
            if (finish && state_q == IBUSY) i_err_q <= abort;
            if (abort)                      tmo_q   <= 1'b1;
        end
    end

    assign d_error_o = d_err_q;
    assign i_error_o = i_err_q;
    assign timeout_o = tmo_q;
`else
    assign abort     = 1'b0;
    assign d_error_o = 1'b0;
    assign i_error_o = 1'b0;
    assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch/data handshakes, starvation limit, hold, reset abort, optional watchdog.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold_i;
    logic        i_rd_i;
    logic [31:0] i_pc_i;
    logic        i_accept_o, i_valid_o, i_error_o;
    logic [31:0] i_inst_o;
    logic        d_rd_i;
    logic [3:0]  d_wr_i;
    logic [31:0] d_addr_i, d_wdata_i;
    logic [10:0] d_tag_i;
    logic        d_accept_o, d_ack_o, d_error_o;
    logic [31:0] d_rdata_o;
    logic [10:0] d_resp_tag_o;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_we, mem_re, mem_ready, timeout_o;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .hold_i(hold_i),
        .i_rd_i(i_rd_i), .i_pc_i(i_pc_i), .i_accept_o(i_accept_o), .i_valid_o(i_valid_o),
        .i_inst_o(i_inst_o), .i_error_o(i_error_o),
        .d_rd_i(d_rd_i), .d_wr_i(d_wr_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_tag_i(d_tag_i), .d_accept_o(d_accept_o), .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
        .d_error_o(d_error_o), .d_resp_tag_o(d_resp_tag_o),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hold_i = 1'b0; i_rd_i = 1'b0; i_pc_i = '0;
        d_rd_i = 1'b0; d_wr_i = '0; d_addr_i = '0; d_wdata_i = '0; d_tag_i = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        #3;
        n_cmp++;
        if ({mem_we, mem_re, i_valid_o, d_ack_o, i_accept_o, d_accept_o, timeout_o, i_error_o, d_error_o} !== 9'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b expected 0", {mem_we, mem_re, i_valid_o, d_ack_o, i_accept_o, d_accept_o, timeout_o, i_error_o, d_error_o});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, mem_wstrb, d_rdata_o, i_inst_o, d_resp_tag_o} !== '0) begin
            n_err++; $display("FAIL reset_data: got nonzero, expected all 0");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        i_rd_i = 1'b1; i_pc_i = 32'h100; mem_ready = 1'b1; mem_rdata = 32'h13;
        #1;
        n_cmp++;
        if (i_accept_o !== 1'b1 || d_accept_o !== 1'b0) begin
            n_err++; $display("FAIL fetch_accept: got i=%b d=%b expected i=1 d=0", i_accept_o, d_accept_o);
        end
        tick();
        i_rd_i = 1'b0;
        #1;
        n_cmp++;
        if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || i_accept_o !== 1'b0) begin
            n_err++; $display("FAIL fetch_strobe: got re=%b we=%b addr=%h acc=%b expected re=1 we=0 addr=100 acc=0", mem_re, mem_we, mem_addr, i_accept_o);
        end
        tick();
        n_cmp++;
        if (i_valid_o !== 1'b1 || i_inst_o !== 32'h13 || mem_re !== 1'b0 || i_error_o !== 1'b0) begin
            n_err++; $display("FAIL fetch_resp: got v=%b inst=%h re=%b err=%b expected v=1 inst=13 re=0 err=0", i_valid_o, i_inst_o, mem_re, i_error_o);
        end
        tick();
        n_cmp++;
        if (i_valid_o !== 1'b0 || i_inst_o !== 32'h13) begin
            n_err++; $display("FAIL fetch_hold: got v=%b inst=%h expected v=0 inst=13", i_valid_o, i_inst_o);
        end
    endtask

    task automatic test_write_wait();
        mem_ready = 1'b0; mem_rdata = 32'h1234_5678;
        d_wr_i = 4'b0011; d_addr_i = 32'h2004; d_wdata_i = 32'hDEAD_BEEF; d_tag_i = 11'h5A;
        #1;
        n_cmp++;
        if (d_accept_o !== 1'b1) begin
            n_err++; $display("FAIL wr_accept: got %b expected 1", d_accept_o);
        end
        tick();
        d_wr_i = '0; d_tag_i = 11'h7FF;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) mem_ready = 1'b1;
            #1;
            n_cmp++;
            if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_wstrb !== 4'b0011 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h2004 || d_ack_o !== 1'b0) begin
                n_err++; $display("FAIL wr_busy_c%0d: got we=%b re=%b strb=%b wd=%h a=%h ack=%b expected we=1 re=0 strb=0011 wd=deadbeef a=2004 ack=0",
                                  c, mem_we, mem_re, mem_wstrb, mem_wdata, mem_addr, d_ack_o);
            end
            tick();
        end
        mem_ready = 1'b0;
        n_cmp++;
        if (d_ack_o !== 1'b1 || d_resp_tag_o !== 11'h5A || d_rdata_o !== 32'h0 || mem_we !== 1'b0) begin
            n_err++; $display("FAIL wr_resp: got ack=%b tag=%h rd=%h we=%b expected ack=1 tag=5a rd=0 we=0", d_ack_o, d_resp_tag_o, d_rdata_o, mem_we);
        end
        tick();
        n_cmp++;
        if (d_ack_o !== 1'b0 || d_resp_tag_o !== 11'h5A) begin
            n_err++; $display("FAIL wr_single_pulse: got ack=%b tag=%h expected ack=0 tag=5a", d_ack_o, d_resp_tag_o);
        end
    endtask

    task automatic test_back_to_back();
        mem_ready = 1'b1; mem_rdata = 32'hA5A5_0001;
        d_rd_i = 1'b1; d_addr_i = 32'h40; d_tag_i = 11'h011;
        #1;
        n_cmp++;
        if (d_accept_o !== 1'b1) begin
            n_err++; $display("FAIL b2b_acc0: got %b expected 1", d_accept_o);
        end
        tick();
        #1;
        n_cmp++;
        if (d_accept_o !== 1'b0 || mem_re !== 1'b1 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin
            n_err++; $display("FAIL b2b_busy: got acc=%b re=%b wd=%h strb=%b expected acc=0 re=1 wd=0 strb=0", d_accept_o, mem_re, mem_wdata, mem_wstrb);
        end
        tick();
        d_tag_i = 11'h022;
        #1;
        n_cmp++;
        if (d_ack_o !== 1'b1 || d_rdata_o !== 32'hA5A5_0001 || d_resp_tag_o !== 11'h011 || d_accept_o !== 1'b1) begin
            n_err++; $display("FAIL b2b_resp_reaccept: got ack=%b rd=%h tag=%h acc=%b expected ack=1 rd=a5a50001 tag=011 acc=1", d_ack_o, d_rdata_o, d_resp_tag_o, d_accept_o);
        end
        tick();
        d_rd_i = 1'b0;
        tick();
        n_cmp++;
        if (d_ack_o !== 1'b1 || d_resp_tag_o !== 11'h022) begin
            n_err++; $display("FAIL b2b_resp2: got ack=%b tag=%h expected ack=1 tag=022", d_ack_o, d_resp_tag_o);
        end
    endtask

    task automatic test_starvation();
        logic seq [10];
        logic exp_seq [10];
        int n = 0;
        int cyc = 0;
        exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        mem_ready = 1'b1;
        d_rd_i = 1'b1; i_rd_i = 1'b1; i_pc_i = 32'h300; d_addr_i = 32'h500;
        while (n < 10 && cyc < 40) begin
            #1;
            if (d_accept_o && i_accept_o) begin
                n_cmp++; n_err++;
                $display("FAIL starve_both: got both accepts expected at most one");
            end
            if (d_accept_o) begin seq[n] = 1'b0; n++; end
            else if (i_accept_o) begin seq[n] = 1'b1; n++; end
            tick();
            cyc++;
        end
        d_rd_i = 1'b0; i_rd_i = 1'b0;
        n_cmp++;
        if (n != 10) begin
            n_err++; $display("FAIL starve_count: got %0d grants expected 10", n);
        end
        for (int k = 0; k < n; k++) begin
            n_cmp++;
            if (seq[k] !== exp_seq[k]) begin
                n_err++; $display("FAIL starve_seq%0d: got %s expected %s", k, seq[k] ? "I" : "D", exp_seq[k] ? "I" : "D");
            end
        end
        tick();
        tick();
    endtask

    task automatic test_hold();
        hold_i = 1'b1; d_rd_i = 1'b1; i_rd_i = 1'b1;
        d_addr_i = 32'h3000; d_tag_i = 11'h123; mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++;
            if (d_accept_o !== 1'b0 || i_accept_o !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0) begin
                n_err++; $display("FAIL hold_c%0d: got dacc=%b iacc=%b re=%b we=%b expected all 0", c, d_accept_o, i_accept_o, mem_re, mem_we);
            end
            tick();
        end
        hold_i = 1'b0;
        #1;
        n_cmp++;
        if (d_accept_o !== 1'b1 || i_accept_o !== 1'b0) begin
            n_err++; $display("FAIL hold_release: got dacc=%b iacc=%b expected dacc=1 iacc=0", d_accept_o, i_accept_o);
        end
        tick();
        d_rd_i = 1'b0; i_rd_i = 1'b0;
        #1;
        n_cmp++;
        if (mem_re !== 1'b1 || mem_addr !== 32'h3000) begin
            n_err++; $display("FAIL hold_strobe: got re=%b addr=%h expected re=1 addr=3000", mem_re, mem_addr);
        end
        tick();
        n_cmp++;
        if (d_ack_o !== 1'b1 || d_rdata_o !== 32'hCAFE_F00D || d_resp_tag_o !== 11'h123) begin
            n_err++; $display("FAIL hold_resp: got ack=%b rd=%h tag=%h expected ack=1 rd=cafef00d tag=123", d_ack_o, d_rdata_o, d_resp_tag_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b0; d_rd_i = 1'b1; d_addr_i = 32'h44;
        #1;
        n_cmp++;
        if (d_accept_o !== 1'b1) begin
            n_err++; $display("FAIL rmid_accept: got %b expected 1", d_accept_o);
        end
        tick();
        d_rd_i = 1'b0;
        tick();
        n_cmp++;
        if (mem_re !== 1'b1) begin
            n_err++; $display("FAIL rmid_busy: got re=%b expected 1", mem_re);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_re !== 1'b0 || mem_addr !== 32'h0 || d_ack_o !== 1'b0) begin
            n_err++; $display("FAIL rmid_clear: got re=%b addr=%h ack=%b expected 0 0 0", mem_re, mem_addr, d_ack_o);
        end
        tick();
        rst_n = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0000_0067;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (d_ack_o !== 1'b0) begin
                n_err++; $display("FAIL rmid_noack_c%0d: got %b expected 0", c, d_ack_o);
            end
        end
        i_rd_i = 1'b1; i_pc_i = 32'h200;
        #1;
        n_cmp++;
        if (i_accept_o !== 1'b1) begin
            n_err++; $display("FAIL rmid_regrant: got %b expected 1", i_accept_o);
        end
        tick();
        i_rd_i = 1'b0;
        tick();
        n_cmp++;
        if (i_valid_o !== 1'b1 || i_inst_o !== 32'h67) begin
            n_err++; $display("FAIL rmid_fetch_resp: got v=%b inst=%h expected v=1 inst=67", i_valid_o, i_inst_o);
        end
        tick();
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int cyc = 0;
        mem_ready = 1'b0; mem_rdata = 32'h5555_5555;
        d_rd_i = 1'b1; d_addr_i = 32'h80; d_tag_i = 11'h0AB;
        tick();
        d_rd_i = 1'b0;
        while (d_ack_o !== 1'b1 && cyc < 30) begin
            tick();
            cyc++;
        end
        n_cmp++;
        if (d_ack_o !== 1'b1 || d_error_o !== 1'b1 || d_rdata_o !== 32'h0 || timeout_o !== 1'b1) begin
            n_err++; $display("FAIL tmo_abort: got ack=%b err=%b rd=%h to=%b expected ack=1 err=1 rd=0 to=1", d_ack_o, d_error_o, d_rdata_o, timeout_o);
        end
        mem_ready = 1'b1; d_rd_i = 1'b1; d_tag_i = 11'h0CD;
        #1;
        n_cmp++;
        if (d_accept_o !== 1'b1) begin
            n_err++; $display("FAIL tmo_next_accept: got %b expected 1", d_accept_o);
        end
        tick();
        d_rd_i = 1'b0;
        tick();
        n_cmp++;
        if (d_ack_o !== 1'b1 || d_error_o !== 1'b0 || d_rdata_o !== 32'h5555_5555 || timeout_o !== 1'b1) begin
            n_err++; $display("FAIL tmo_next_resp: got ack=%b err=%b rd=%h to=%b expected ack=1 err=0 rd=55555555 to=1", d_ack_o, d_error_o, d_rdata_o, timeout_o);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_write_wait();
        test_back_to_back();
        test_starvation();
        test_hold();
        test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
